// File: rtl/ntr_pkg.sv
// Shared types and constants for the NTR card-bus command sequencer.
package ntr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } ntr_state_t;

    localparam int         NTR_CMD_BYTES = 8;
    localparam logic [7:0] NTR_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/ntr_cmd_sequencer_if.sv
// Command/response handshake bundle between the sequencer and the decoder/response source.
interface ntr_cmd_sequencer_if
    import ntr_pkg::*;
#(
    parameter int CMD_BYTES  = NTR_CMD_BYTES,
    parameter int RESP_LEN_W = 14
);
    logic                   cmd_valid;
    logic [8*CMD_BYTES-1:0] cmd_data;
    logic                   cmd_ready;
    logic [RESP_LEN_W-1:0]  resp_len;
    logic [7:0]             resp_data;
    logic                   resp_valid;
    logic                   resp_ready;

    modport master (
        output cmd_valid, cmd_data, resp_ready,
        input  cmd_ready, resp_len, resp_data, resp_valid
    );

    modport slave (
        input  cmd_valid, cmd_data, resp_ready,
        output cmd_ready, resp_len, resp_data, resp_valid
    );
endinterface

// File: rtl/ntr_edge_sync.sv
// Multi-flop synchronizer for one async bit with rise/fall pulses derived from the synced copy.
module ntr_edge_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], async_in};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;
endmodule

// File: rtl/ntr_cmd_sequencer.sv
// Runs one NTR bus transaction: capture the command frame, hand it off, stream the response back.
module ntr_cmd_sequencer
    import ntr_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CMD_BYTES   = NTR_CMD_BYTES,
    parameter int RESP_LEN_W  = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ntr_clk,
    input  logic                ntr_cs_n,
    input  logic [7:0]          ntr_data_in,
    output logic [7:0]          ntr_data_out,
    output logic                ntr_data_oe,
    ntr_cmd_sequencer_if.master bus,
    output logic                err_underrun,
    output logic [1:0]          state_dbg
);
    localparam int CNT_W = $clog2(CMD_BYTES + 1);

    ntr_state_t            state;
    logic [CNT_W-1:0]      byte_cnt;
    logic [RESP_LEN_W-1:0] remaining;
    logic [7:0]            data_chain [SYNC_STAGES];
    logic [7:0]            data_sync;
    logic                  clk_level, clk_rise, clk_fall;
    logic                  cs_level, cs_rise, cs_fall;
    logic                  unused_sync;

    function automatic logic [RESP_LEN_W-1:0] sat_dec(input logic [RESP_LEN_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    ntr_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_clk_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (ntr_clk),
        .level    (clk_level),
        .rise     (clk_rise),
        .fall     (clk_fall)
    );

    // Chip select idles high, so its chain resets high to avoid a spurious select after reset.
    ntr_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (ntr_cs_n),
        .level    (cs_level),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    // Same depth as the strobe chains so the byte lines up with the synced ntr_clk rise.
    always_ff @(posedge clk) begin
        data_chain[0] <= ntr_data_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            data_chain[i] <= data_chain[i-1];
        end
    end

    assign data_sync   = data_chain[SYNC_STAGES-1];
    assign state_dbg   = state;
    assign unused_sync = &{1'b0, clk_level, cs_rise};

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            byte_cnt      <= '0;
            remaining     <= '0;
            bus.cmd_data  <= '0;
            bus.cmd_valid <= 1'b0;
            bus.resp_ready <= 1'b0;
            ntr_data_out  <= NTR_IDLE_BYTE;
            ntr_data_oe   <= 1'b0;
            err_underrun  <= 1'b0;
        end else begin
            bus.resp_ready <= 1'b0;
            if (state != IDLE && cs_level) begin
                // Deselect aborts everywhere; any clock edge this cycle is dropped.
                state         <= IDLE;
                bus.cmd_valid <= 1'b0;
                ntr_data_oe   <= 1'b0;
                ntr_data_out  <= NTR_IDLE_BYTE;
            end else begin
                case (state)
                    IDLE: begin
                        ntr_data_oe <= 1'b0;
                        if (cs_fall) begin
                            state        <= CMD;
                            byte_cnt     <= '0;
                            err_underrun <= 1'b0;
                        end
                    end
                    CMD: begin
                        if (clk_rise) begin
                            bus.cmd_data <= {bus.cmd_data[8*CMD_BYTES-9:0], data_sync};
                            byte_cnt     <= byte_cnt + 1'b1;
                            if (byte_cnt == CNT_W'(CMD_BYTES - 1)) begin
                                state         <= WAIT;
                                bus.cmd_valid <= 1'b1;
                            end
                        end
                    end
                    WAIT: begin
                        if (bus.cmd_ready) begin
                            bus.cmd_valid <= 1'b0;
                            remaining     <= bus.resp_len;
                            if (bus.resp_len == '0) begin
                                state <= IDLE;
                            end else begin
                                state       <= RESP;
                                ntr_data_oe <= 1'b1;
                            end
                        end
                    end
                    RESP: begin
                        if (clk_fall && remaining != '0) begin
                            remaining <= sat_dec(remaining);
                            if (bus.resp_valid) begin
                                ntr_data_out   <= bus.resp_data;
                                bus.resp_ready <= 1'b1;
                            end else begin
                                ntr_data_out <= NTR_IDLE_BYTE;
                                err_underrun <= 1'b1;
                            end
                        end else if (clk_rise && remaining == '0) begin
                            // Host has sampled the last byte; release the bus.
                            state        <= IDLE;
                            ntr_data_oe  <= 1'b0;
                            ntr_data_out <= NTR_IDLE_BYTE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ntr_cmd_sequencer.sv
// Scenario bench for ntr_cmd_sequencer: drives NTR bus transactions and scoreboards frames and response bytes.
module tb_ntr_cmd_sequencer;
    import ntr_pkg::*;

    localparam int HALF = 6;

    logic       clk;
    logic       rst;
    logic       ntr_clk;
    logic       ntr_cs_n;
    logic [7:0] ntr_data_in;
    logic [7:0] ntr_data_out;
    logic       ntr_data_oe;
    logic       err_underrun;
    logic [1:0] state_dbg;

    ntr_cmd_sequencer_if #(.CMD_BYTES(8), .RESP_LEN_W(14)) bus ();

    ntr_cmd_sequencer #(.SYNC_STAGES(2), .CMD_BYTES(8), .RESP_LEN_W(14)) dut (
        .clk          (clk),
        .rst          (rst),
        .ntr_clk      (ntr_clk),
        .ntr_cs_n     (ntr_cs_n),
        .ntr_data_in  (ntr_data_in),
        .ntr_data_out (ntr_data_out),
        .ntr_data_oe  (ntr_data_oe),
        .bus          (bus),
        .err_underrun (err_underrun),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    // Monitors: consumed response bytes, cmd_valid assertions, cycles with oe high.
    int   rr_cnt;
    int   cv_rises;
    int   oe_cycles;
    logic cv_q;
    always @(posedge clk) begin
        if (rst) begin
            rr_cnt    <= 0;
            cv_rises  <= 0;
            oe_cycles <= 0;
            cv_q      <= 1'b0;
        end else begin
            if (bus.resp_ready) rr_cnt <= rr_cnt + 1;
            if (bus.cmd_valid && !cv_q) cv_rises <= cv_rises + 1;
            if (ntr_data_oe) oe_cycles <= oe_cycles + 1;
            cv_q <= bus.cmd_valid;
        end
    end

    // Response source: advances one entry per resp_ready pulse; src_stall withholds valid.
    logic [7:0] src_mem [8];
    int         src_n;
    int         src_base;
    logic       src_stall;
    int         src_idx;
    always_comb begin
        src_idx        = rr_cnt - src_base;
        bus.resp_valid = (src_idx >= 0) && (src_idx < src_n) && !src_stall;
        bus.resp_data  = bus.resp_valid ? src_mem[src_idx[2:0]] : 8'h00;
    end

    logic [63:0] cmd_q [$];
    logic [7:0]  bus_q [$];

    task automatic ntr_rise(input logic [7:0] b);
        ntr_data_in = b;
        ntr_clk     = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic ntr_fall();
        ntr_clk = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_set(input logic v);
        ntr_cs_n = v;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_frame(input logic [63:0] f, input int nbytes);
        if (nbytes == 8) cmd_q.push_back(f);
        for (int i = 0; i < nbytes; i++) begin
            ntr_rise(f[63-8*i -: 8]);
            ntr_fall();
        end
    endtask

    task automatic wait_cmd_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.cmd_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic load_src(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input int n);
        src_mem[0] = b0;
        src_mem[1] = b1;
        src_mem[2] = b2;
        src_mem[3] = b3;
        src_n      = n;
        src_base   = rr_cnt;
        src_stall  = 1'b0;
    endtask

    task automatic handshake(input logic [13:0] len);
        bus.resp_len  = len;
        bus.cmd_ready = 1'b1;
        @(negedge clk);
        bus.cmd_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
        n_tests++; if (ntr_data_out !== 8'hFF) begin n_fail++; $display("FAIL reset_data_out got=%h exp=ff", ntr_data_out); end
        n_tests++; if (ntr_data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe got=%b exp=0", ntr_data_oe); end
        n_tests++; if (bus.cmd_valid !== 1'b0 || bus.resp_ready !== 1'b0) begin n_fail++; $display("FAIL reset_handshake cmd_valid=%b resp_ready=%b exp=0,0", bus.cmd_valid, bus.resp_ready); end
        n_tests++; if (err_underrun !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err_underrun); end
        n_tests++; if (bus.cmd_data !== 64'h0) begin n_fail++; $display("FAIL reset_cmd_data got=%h exp=0", bus.cmd_data); end
    endtask

    task automatic test_cmd_capture();
        bit ok;
        logic [63:0] exp;
        cs_set(1'b0);
        n_tests++; if (state_dbg !== 2'd1) begin n_fail++; $display("FAIL cap_state_cmd got=%0d exp=1", state_dbg); end
        send_frame(64'h0001020304050607, 8);
        wait_cmd_valid(ok);
        exp = cmd_q.pop_front();
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL cap_cmd_valid got=%b exp=1", ok); end
        n_tests++; if (bus.cmd_data !== exp) begin n_fail++; $display("FAIL cap_cmd_data got=%h exp=%h", bus.cmd_data, exp); end
        n_tests++; if (state_dbg !== 2'd2) begin n_fail++; $display("FAIL cap_state_wait got=%0d exp=2", state_dbg); end
    endtask

    task automatic test_response();
        bit stable;
        int rr0;
        logic [7:0] exp;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.cmd_valid !== 1'b1 || bus.cmd_data !== 64'h0001020304050607) stable = 1'b0;
        end
        n_tests++; if (stable !== 1'b1) begin n_fail++; $display("FAIL resp_hold_valid got=%b exp=1", stable); end
        load_src(8'hAA, 8'hBB, 8'hCC, 8'hDD, 4);
        bus_q.push_back(8'hAA); bus_q.push_back(8'hBB); bus_q.push_back(8'hCC); bus_q.push_back(8'hDD);
        rr0 = rr_cnt;
        handshake(14'd4);
        n_tests++; if (bus.cmd_valid !== 1'b0 || state_dbg !== 2'd3 || ntr_data_oe !== 1'b1) begin n_fail++; $display("FAIL resp_enter valid=%b state=%0d oe=%b exp=0,3,1", bus.cmd_valid, state_dbg, ntr_data_oe); end
        for (int i = 0; i < 4; i++) begin
            ntr_rise(8'h00);
            ntr_fall();
            exp = bus_q.pop_front();
            n_tests++; if (ntr_data_out !== exp) begin n_fail++; $display("FAIL resp_byte%0d got=%h exp=%h", i, ntr_data_out, exp); end
        end
        n_tests++; if (state_dbg !== 2'd3 || ntr_data_oe !== 1'b1) begin n_fail++; $display("FAIL resp_hold_last state=%0d oe=%b exp=3,1", state_dbg, ntr_data_oe); end
        ntr_rise(8'h00);
        n_tests++; if (state_dbg !== 2'd0 || ntr_data_oe !== 1'b0 || ntr_data_out !== 8'hFF) begin n_fail++; $display("FAIL resp_done state=%0d oe=%b out=%h exp=0,0,ff", state_dbg, ntr_data_oe, ntr_data_out); end
        n_tests++; if (rr_cnt - rr0 !== 4) begin n_fail++; $display("FAIL resp_ready_pulses got=%0d exp=4", rr_cnt - rr0); end
        ntr_fall();
        cs_set(1'b1);
    endtask

    task automatic test_zero_len();
        bit ok;
        int oe0, rr0;
        logic [63:0] exp;
        cs_set(1'b0);
        send_frame(64'h1122334455667788, 8);
        wait_cmd_valid(ok);
        exp = cmd_q.pop_front();
        n_tests++; if (ok !== 1'b1 || bus.cmd_data !== exp) begin n_fail++; $display("FAIL zero_cmd valid=%b data=%h exp=1,%h", ok, bus.cmd_data, exp); end
        oe0 = oe_cycles;
        rr0 = rr_cnt;
        handshake(14'd0);
        n_tests++; if (state_dbg !== 2'd0 || bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL zero_idle state=%0d valid=%b exp=0,0", state_dbg, bus.cmd_valid); end
        ntr_rise(8'h00);
        ntr_fall();
        n_tests++; if (oe_cycles - oe0 !== 0 || rr_cnt - rr0 !== 0) begin n_fail++; $display("FAIL zero_no_resp oe_cycles=%0d resp_ready=%0d exp=0,0", oe_cycles - oe0, rr_cnt - rr0); end
        cs_set(1'b1);
    endtask

    task automatic test_underrun();
        bit ok;
        int rr0;
        logic [63:0] exp;
        logic [7:0]  eb;
        cs_set(1'b0);
        send_frame(64'hA0A1A2A3A4A5A6A7, 8);
        wait_cmd_valid(ok);
        exp = cmd_q.pop_front();
        n_tests++; if (ok !== 1'b1 || bus.cmd_data !== exp) begin n_fail++; $display("FAIL urun_cmd valid=%b data=%h exp=1,%h", ok, bus.cmd_data, exp); end
        load_src(8'hAA, 8'hCC, 8'h00, 8'h00, 2);
        bus_q.push_back(8'hAA); bus_q.push_back(8'hFF); bus_q.push_back(8'hCC);
        rr0 = rr_cnt;
        handshake(14'd3);
        for (int i = 0; i < 3; i++) begin
            src_stall = (i == 1);
            ntr_rise(8'h00);
            ntr_fall();
            src_stall = 1'b0;
            eb = bus_q.pop_front();
            n_tests++; if (ntr_data_out !== eb) begin n_fail++; $display("FAIL urun_byte%0d got=%h exp=%h", i, ntr_data_out, eb); end
        end
        n_tests++; if (err_underrun !== 1'b1) begin n_fail++; $display("FAIL urun_err_set got=%b exp=1", err_underrun); end
        ntr_rise(8'h00);
        n_tests++; if (state_dbg !== 2'd0 || rr_cnt - rr0 !== 2) begin n_fail++; $display("FAIL urun_done state=%0d pulses=%0d exp=0,2", state_dbg, rr_cnt - rr0); end
        ntr_fall();
        cs_set(1'b1);
        n_tests++; if (err_underrun !== 1'b1) begin n_fail++; $display("FAIL urun_err_sticky got=%b exp=1", err_underrun); end
    endtask

    task automatic test_abort();
        bit ok;
        int cv0;
        logic [63:0] exp;
        cv0 = cv_rises;
        cs_set(1'b0);
        n_tests++; if (err_underrun !== 1'b0) begin n_fail++; $display("FAIL abort_err_clear got=%b exp=0", err_underrun); end
        send_frame(64'h5152530000000000, 3);
        cs_set(1'b1);
        n_tests++; if (state_dbg !== 2'd0 || cv_rises - cv0 !== 0) begin n_fail++; $display("FAIL abort_idle state=%0d cmd_valids=%0d exp=0,0", state_dbg, cv_rises - cv0); end
        cs_set(1'b0);
        send_frame(64'hFFFFFFFFFFFFFFFF, 8);
        wait_cmd_valid(ok);
        exp = cmd_q.pop_front();
        n_tests++; if (ok !== 1'b1 || bus.cmd_data !== exp) begin n_fail++; $display("FAIL abort_refill valid=%b data=%h exp=1,%h", ok, bus.cmd_data, exp); end
        n_tests++; if (cv_rises - cv0 !== 1) begin n_fail++; $display("FAIL abort_valid_count got=%0d exp=1", cv_rises - cv0); end
    endtask

    task automatic test_rst_mid();
        bit ok;
        logic [63:0] exp;
        cs_set(1'b1);
        n_tests++; if (state_dbg !== 2'd0 || bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rstm_wait_abort state=%0d valid=%b exp=0,0", state_dbg, bus.cmd_valid); end
        cs_set(1'b0);
        send_frame(64'h0F0E0D0C0B0A0908, 8);
        wait_cmd_valid(ok);
        exp = cmd_q.pop_front();
        n_tests++; if (ok !== 1'b1 || bus.cmd_data !== exp) begin n_fail++; $display("FAIL rstm_cmd valid=%b data=%h exp=1,%h", ok, bus.cmd_data, exp); end
        load_src(8'h11, 8'h22, 8'h33, 8'h00, 3);
        handshake(14'd3);
        ntr_rise(8'h00);
        ntr_fall();
        n_tests++; if (ntr_data_out !== 8'h11 || state_dbg !== 2'd3) begin n_fail++; $display("FAIL rstm_byte0 out=%h state=%0d exp=11,3", ntr_data_out, state_dbg); end
        ntr_rise(8'h00);
        ntr_clk = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++; if (state_dbg !== 2'd0 || ntr_data_oe !== 1'b0 || ntr_data_out !== 8'hFF || bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rstm_state state=%0d oe=%b out=%h valid=%b exp=0,0,ff,0", state_dbg, ntr_data_oe, ntr_data_out, bus.cmd_valid); end
        n_tests++; if (bus.cmd_data !== 64'h0) begin n_fail++; $display("FAIL rstm_cmd_data got=%h exp=0", bus.cmd_data); end
        cs_set(1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clk           = 1'b0;
        rst           = 1'b1;
        ntr_clk       = 1'b0;
        ntr_cs_n      = 1'b1;
        ntr_data_in   = 8'h00;
        bus.cmd_ready = 1'b0;
        bus.resp_len  = '0;
        n_tests       = 0;
        n_fail        = 0;
        src_n         = 0;
        src_base      = 0;
        src_stall     = 1'b0;
        for (int i = 0; i < 8; i++) src_mem[i] = 8'h00;

        test_reset();
        test_cmd_capture();
        test_response();
        test_zero_len();
        test_underrun();
        test_abort();
        test_rst_mid();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
